// File: rtl/hazard_sched_pkg.sv
// Shared pipeline constants and small hazard/forwarding helpers used by the
// hazard scheduler and its mult/div busy counter.
package hazard_sched_pkg;

    // Tuse encoding for "this source is never read"
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    // Forwarding mux selects shared by the D and E stage bypass muxes
    typedef enum logic [1:0] {
        FWD_DEF = 2'd0,
        FWD_M   = 2'd1,
        FWD_W   = 2'd2
    } fwd_sel_e;

    // Default md unit occupancy after issue in E
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // A source depends on a producer when it names the producer's destination,
    // the producer really writes, and the register is not the hardwired $0.
    function automatic logic src_match(input logic [4:0] src,
                                       input logic [4:0] dst,
                                       input logic       we);
        return (src != 5'd0) && we && (src == dst);
    endfunction

    // The consumer needs the value before the producer can supply it.
    function automatic logic src_late(input logic [1:0] tuse,
                                      input logic [1:0] tnew);
        return (tuse != TUSE_NEVER) && (tuse < tnew);
    endfunction

    // Youngest-first bypass selection: M (only once AO_M is valid) beats W.
    function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                            input logic [4:0] a_m,
                                            input logic       we_m,
                                            input logic [1:0] tnew_m,
                                            input logic [4:0] a_w,
                                            input logic       we_w);
        fwd_sel_e sel;
        if (src_match(src, a_m, we_m) && (tnew_m == 2'd0)) begin
            sel = FWD_M;
        end else if (src_match(src, a_w, we_w)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_DEF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Pipeline-side view of the hazard scheduler: stage register numbers and
// timing info in, hold/flush/forwarding controls out.
interface hazard_sched_if #(
    parameter int STALL_CNT_W = 32
);
    // D stage sources
    logic [4:0]             rs_D;
    logic [4:0]             rt_D;
    logic [1:0]             tuse_rs_D;
    logic [1:0]             tuse_rt_D;
    logic                   md_D;
    // E stage
    logic [4:0]             rs_E;
    logic [4:0]             rt_E;
    logic [4:0]             a_E;
    logic                   we_E;
    logic [1:0]             tnew_E;
    logic                   md_start_E;
    logic                   md_div_E;
    // M and W stages
    logic [4:0]             a_M;
    logic                   we_M;
    logic [1:0]             tnew_M;
    logic [4:0]             a_W;
    logic                   we_W;
    // Controls back to the pipeline
    logic                   pc_en;
    logic                   hold_D;
    logic                   clr_E;
    logic [1:0]             fwd_rs_D;
    logic [1:0]             fwd_rt_D;
    logic [1:0]             fwd_rs_E;
    logic [1:0]             fwd_rt_E;
    logic                   md_busy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Pipeline side: supplies stage info, consumes controls
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        output rs_E, rt_E, a_E, we_E, tnew_E, md_start_E, md_div_E,
        output a_M, we_M, tnew_M, a_W, we_W,
        input  pc_en, hold_D, clr_E,
        input  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
        input  md_busy, stall_cnt
    );

    // Scheduler side
    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        input  rs_E, rt_E, a_E, we_E, tnew_E, md_start_E, md_div_E,
        input  a_M, we_M, tnew_M, a_W, we_W,
        output pc_en, hold_D, clr_E,
        output fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
        output md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_sched_md_busy_ctr.sv
// Mult/div occupancy counter. A start while idle loads the op latency; the
// count then runs down to zero. Busy is registered alongside the count so it
// drops immediately on reset.
module md_busy_ctr
    import hazard_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: load on an accepted start, otherwise run down; a start
    // while busy is dropped and leaves the count alone.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_start && !r_busy) begin
            w_cnt_nxt = i_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (r_busy) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count and busy flag registers; reset aborts an in-flight operation
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage pipeline: Tuse/Tnew stall detection,
// mult/div interlock, D/E forwarding selects and a stall cycle counter.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int MULT_LAT    = MULT_LAT_DEF,
    parameter int DIV_LAT     = DIV_LAT_DEF,
    parameter int STALL_CNT_W = 32
) (
    input  logic          clk,
    input  logic          clr_n,
    hazard_sched_if.slave bus
);
    logic                   w_stall_data;
    logic                   w_stall_md;
    logic                   w_stall;
    logic                   w_md_busy;
    fwd_sel_e               w_fwd_rs_d;
    fwd_sel_e               w_fwd_rt_d;
    fwd_sel_e               w_fwd_rs_e;
    fwd_sel_e               w_fwd_rt_e;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    md_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_ctr (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_start (bus.md_start_E),
        .i_div   (bus.md_div_E),
        .o_busy  (w_md_busy)
    );

    // Stall decision: a D source produced too late by E or M, or a HI/LO user
    // while the md unit is occupied or just being issued.
    always_comb begin
        w_stall_data = (src_match(bus.rs_D, bus.a_E, bus.we_E) && src_late(bus.tuse_rs_D, bus.tnew_E))
                     | (src_match(bus.rs_D, bus.a_M, bus.we_M) && src_late(bus.tuse_rs_D, bus.tnew_M))
                     | (src_match(bus.rt_D, bus.a_E, bus.we_E) && src_late(bus.tuse_rt_D, bus.tnew_E))
                     | (src_match(bus.rt_D, bus.a_M, bus.we_M) && src_late(bus.tuse_rt_D, bus.tnew_M));
        w_stall_md   = bus.md_D & (w_md_busy | bus.md_start_E);
        w_stall      = w_stall_data | w_stall_md;
    end

    // Bypass selects for both consuming stages
    always_comb begin
        w_fwd_rs_d = fwd_select(bus.rs_D, bus.a_M, bus.we_M, bus.tnew_M, bus.a_W, bus.we_W);
        w_fwd_rt_d = fwd_select(bus.rt_D, bus.a_M, bus.we_M, bus.tnew_M, bus.a_W, bus.we_W);
        w_fwd_rs_e = fwd_select(bus.rs_E, bus.a_M, bus.we_M, bus.tnew_M, bus.a_W, bus.we_W);
        w_fwd_rt_e = fwd_select(bus.rt_E, bus.a_M, bus.we_M, bus.tnew_M, bus.a_W, bus.we_W);
    end

    // Pipeline controls; held at their free-running values while in reset
    always_comb begin
        bus.pc_en    = 1'b1;
        bus.hold_D   = 1'b0;
        bus.clr_E    = 1'b0;
        bus.fwd_rs_D = FWD_DEF;
        bus.fwd_rt_D = FWD_DEF;
        bus.fwd_rs_E = FWD_DEF;
        bus.fwd_rt_E = FWD_DEF;
        if (!clr_n) begin
            bus.pc_en    = 1'b1;
            bus.hold_D   = 1'b0;
            bus.clr_E    = 1'b0;
            bus.fwd_rs_D = FWD_DEF;
            bus.fwd_rt_D = FWD_DEF;
            bus.fwd_rs_E = FWD_DEF;
            bus.fwd_rt_E = FWD_DEF;
        end else begin
            bus.pc_en    = ~w_stall;
            bus.hold_D   = w_stall;
            bus.clr_E    = w_stall;
            bus.fwd_rs_D = w_fwd_rs_d;
            bus.fwd_rt_D = w_fwd_rt_d;
            bus.fwd_rs_E = w_fwd_rs_e;
            bus.fwd_rt_E = w_fwd_rt_e;
        end
    end

    // Stall cycle counter, wraps naturally at its width
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.md_busy   = w_md_busy;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_hazard_sched;
    localparam int SW = 8;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    hazard_sched_if #(.STALL_CNT_W(SW)) bus ();

    hazard_sched #(
        .MULT_LAT    (5),
        .DIV_LAT     (10),
        .STALL_CNT_W (SW)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // md occupancy is tracked as "busy through cycle busy_end" on a free cycle count.
    int cyc      = 0;
    int busy_end = -1;
    int m_cnt    = 0;

    function automatic bit m_busy();
        return clr_n && (cyc <= busy_end);
    endfunction

    function automatic bit late(input logic [4:0] src, input logic [1:0] tuse);
        int need;
        bit r;
        need = (tuse == 2'd3) ? 99 : int'(tuse);
        r = 1'b0;
        if (src == 5'd0) return 1'b0;
        if (bus.we_E && bus.a_E == src && need < int'(bus.tnew_E)) r = 1'b1;
        if (bus.we_M && bus.a_M == src && need < int'(bus.tnew_M)) r = 1'b1;
        return r;
    endfunction

    function automatic bit m_stall();
        if (!clr_n) return 1'b0;
        return late(bus.rs_D, bus.tuse_rs_D) || late(bus.rt_D, bus.tuse_rt_D) ||
               (bus.md_D && (m_busy() || bus.md_start_E));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (!clr_n || src == 5'd0) return 2'd0;
        if (bus.we_M && bus.a_M == src && bus.tnew_M == 2'd0) return 2'd1;
        if (bus.we_W && bus.a_W == src) return 2'd2;
        return 2'd0;
    endfunction

    // Free-running cycle index
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: md occupancy window and stall count
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy_end <= -1;
            m_cnt    <= 0;
        end else begin
            if (bus.md_start_E && !(cyc <= busy_end))
                busy_end <= cyc + (bus.md_div_E ? 10 : 5);
            if (m_stall())
                m_cnt <= (m_cnt + 1) % (1 << SW);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        bit s;
        s = m_stall();
        chk1("pc_en",    bus.pc_en,    ~s);
        chk1("hold_D",   bus.hold_D,   s);
        chk1("clr_E",    bus.clr_E,    s);
        chk2("fwd_rs_D", bus.fwd_rs_D, m_fwd(bus.rs_D));
        chk2("fwd_rt_D", bus.fwd_rt_D, m_fwd(bus.rt_D));
        chk2("fwd_rs_E", bus.fwd_rs_E, m_fwd(bus.rs_E));
        chk2("fwd_rt_E", bus.fwd_rt_E, m_fwd(bus.rt_E));
        chk1("md_busy",  bus.md_busy,  m_busy());
        chkn("stall_cnt", bus.stall_cnt, SW'(m_cnt));
        if (bus.md_start_E && clr_n)
            chk1("start_while_busy", bus.md_busy, 1'b0);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.rs_D = 5'd0; bus.rt_D = 5'd0;
        bus.tuse_rs_D = 2'd3; bus.tuse_rt_D = 2'd3; bus.md_D = 1'b0;
        bus.rs_E = 5'd0; bus.rt_E = 5'd0; bus.a_E = 5'd0; bus.we_E = 1'b0;
        bus.tnew_E = 2'd0; bus.md_start_E = 1'b0; bus.md_div_E = 1'b0;
        bus.a_M = 5'd0; bus.we_M = 1'b0; bus.tnew_M = 2'd0;
        bus.a_W = 5'd0; bus.we_W = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int base;
    int r;

    initial begin
        idle();
        // Reset with hazardous inputs present: controls must stay free-running
        clr_n = 1'b0;
        bus.a_E = 5'd1; bus.we_E = 1'b1; bus.tnew_E = 2'd2;
        bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd0;
        bus.a_M = 5'd1; bus.we_M = 1'b1; bus.rs_E = 5'd1;
        bus.md_D = 1'b1; bus.md_start_E = 1'b1;
        repeat (2) tick();
        #1;
        chk1("rst_pc_en", bus.pc_en, 1'b1);
        chk1("rst_hold_D", bus.hold_D, 1'b0);
        chk2("rst_fwd_rs_E", bus.fwd_rs_E, 2'd0);
        chk1("rst_md_busy", bus.md_busy, 1'b0);
        chkn("rst_stall_cnt", bus.stall_cnt, 8'd0);
        idle();
        clr_n = 1'b1;

        // Load-use: lw $1 in E, D reads $1 with tuse 1
        tick(); idle();
        bus.a_E = 5'd1; bus.we_E = 1'b1; bus.tnew_E = 2'd2;
        bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd1;
        #1;
        chk1("lu_stall_pc_en", bus.pc_en, 1'b0);
        chk1("lu_stall_clr_E", bus.clr_E, 1'b1);
        tick(); idle();
        bus.a_M = 5'd1; bus.we_M = 1'b1; bus.tnew_M = 2'd1;
        bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd1;
        #1;
        chk1("lu_m_pc_en", bus.pc_en, 1'b1);
        chk2("lu_m_fwd", bus.fwd_rs_D, 2'd0);
        chkn("lu_cnt", bus.stall_cnt, 8'd1);
        tick(); idle();
        bus.a_W = 5'd1; bus.we_W = 1'b1;
        bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd1;
        #1;
        chk2("lu_w_fwd", bus.fwd_rs_D, 2'd2);
        chkn("lu_cnt2", bus.stall_cnt, 8'd1);

        // ALU chain: M beats W; W alone forwards 2; tuse 2 vs tnew 2 no stall
        tick(); idle();
        bus.a_M = 5'd2; bus.we_M = 1'b1; bus.tnew_M = 2'd0;
        bus.rs_D = 5'd2; bus.tuse_rs_D = 2'd0; bus.rt_E = 5'd2;
        #1;
        chk1("alu_pc_en", bus.pc_en, 1'b1);
        chk2("alu_fwd_rs_D", bus.fwd_rs_D, 2'd1);
        bus.a_W = 5'd2; bus.we_W = 1'b1;
        #1;
        chk2("alu_m_over_w", bus.fwd_rs_D, 2'd1);
        chk2("alu_m_over_w_E", bus.fwd_rt_E, 2'd1);
        bus.we_M = 1'b0;
        #1;
        chk2("alu_w_only", bus.fwd_rs_D, 2'd2);
        bus.a_E = 5'd3; bus.we_E = 1'b1; bus.tnew_E = 2'd2;
        bus.rt_D = 5'd3; bus.tuse_rt_D = 2'd2;
        #1;
        chk1("tuse_eq_tnew", bus.pc_en, 1'b1);

        // $0 destination never stalls or forwards
        tick(); idle();
        bus.we_E = 1'b1; bus.tnew_E = 2'd2;
        bus.we_M = 1'b1; bus.we_W = 1'b1;
        bus.tuse_rs_D = 2'd0;
        #1;
        chk1("r0_pc_en", bus.pc_en, 1'b1);
        chk2("r0_fwd_rs_D", bus.fwd_rs_D, 2'd0);
        chk2("r0_fwd_rs_E", bus.fwd_rs_E, 2'd0);

        // div then mflo: 10 busy cycles, 10 stalls
        tick(); idle();
        bus.md_start_E = 1'b1; bus.md_div_E = 1'b1;
        base = m_cnt;
        #1;
        chk1("div_issue_pc_en", bus.pc_en, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(); idle();
            bus.md_D = 1'b1;
            #1;
            chk1("div_busy", bus.md_busy, 1'b1);
            chk1("div_stall", bus.pc_en, 1'b0);
        end
        tick(); idle();
        bus.md_D = 1'b1;
        #1;
        chk1("div_done_busy", bus.md_busy, 1'b0);
        chk1("div_done_pc_en", bus.pc_en, 1'b1);
        chkn("div_cnt", bus.stall_cnt, SW'(base + 10));

        // mult aborted by reset at busy cycle 2
        tick(); idle();
        bus.md_start_E = 1'b1;
        tick(); idle();
        #1;
        chk1("mult_busy1", bus.md_busy, 1'b1);
        tick(); idle();
        #1;
        chk1("mult_busy2", bus.md_busy, 1'b1);
        clr_n = 1'b0;
        #1;
        chk1("mult_abort", bus.md_busy, 1'b0);
        tick(); idle();
        clr_n = 1'b1;
        bus.md_D = 1'b1;
        #1;
        chk1("mfhi_after_rst", bus.pc_en, 1'b1);
        chkn("cnt_after_rst", bus.stall_cnt, 8'd0);

        // Stall counter wrap
        idle();
        bus.a_E = 5'd1; bus.we_E = 1'b1; bus.tnew_E = 2'd1;
        bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd0;
        repeat (255) tick();
        #1;
        chkn("wrap_max", bus.stall_cnt, 8'd255);
        tick(); #1;
        chkn("wrap_zero", bus.stall_cnt, 8'd0);
        tick(); #1;
        chkn("wrap_one", bus.stall_cnt, 8'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            clr_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            bus.rs_D = 5'($urandom_range(0, 3));
            bus.rt_D = 5'($urandom_range(0, 3));
            r = int'($urandom_range(0, 2));
            bus.tuse_rs_D = (r == 2) ? 2'd3 : 2'(r);
            bus.tuse_rt_D = 2'($urandom_range(0, 3));
            bus.md_D = ($urandom_range(0, 4) == 0);
            bus.rs_E = 5'($urandom_range(0, 3));
            bus.rt_E = 5'($urandom_range(0, 3));
            bus.a_E = 5'($urandom_range(0, 3));
            bus.we_E = 1'($urandom_range(0, 1));
            bus.tnew_E = 2'($urandom_range(0, 2));
            bus.a_M = 5'($urandom_range(0, 3));
            bus.we_M = 1'($urandom_range(0, 1));
            bus.tnew_M = 2'($urandom_range(0, 1));
            bus.a_W = 5'($urandom_range(0, 3));
            bus.we_W = 1'($urandom_range(0, 1));
            bus.md_div_E = 1'($urandom_range(0, 1));
            bus.md_start_E = !m_busy() && ($urandom_range(0, 7) == 0);
        end
        tick();
        clr_n = 1'b1;
        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
